bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Upstream stage for the shared tri-state bus emulator: conditions raw push-button requests and data, then grants exactly one bus driver at a time. Two-flop synchronization, debouncing and a round-robin arbiter with a turnaround dead cycle guarantee that `drive_a` and `drive_b` are never high together. `value_a`/`value_b` are gated to zero when not granted. Outputs feed the tri-state block's `drive_a`, `drive_b`, `value_a` and `value_b` inputs directly.

## Interface
- `DEBOUNCE`, 3: consecutive stable cycles required before a debounced input changes; legal range 1..15.
- `MAX_HOLD`, 200: maximum grant length in cycles while the other side is waiting; legal range 2..1023.

- `hz100`  in  1  system clock (100 Hz on the board).
- `reset`  in  1  synchronous, active-high reset.
- `req_a`, `req_b`  in  1 each  raw enable requests from buttons; asynchronous to `hz100`.
- `val_a`, `val_b`  in  1 each  raw data bits from buttons; asynchronous.
- `drive_a`, `drive_b`  out  1 each  registered bus enables; mutually exclusive.
- `value_a`, `value_b`  out  1 each  debounced data ANDed with the matching registered enable.
- `owner`  out  2  registered state code: 00 idle, 01 A, 10 B, 11 turnaround.
- `starved`  out  1  registered; high for exactly one cycle when a grant is ended by `MAX_HOLD` preemption.

## Operation
- **Synchronizer.**
  - Each of the 4 raw inputs passes through 2 flops.
  - Flops reset to 0.
- **Debouncer, one per synchronized input.**
  - State: a 4-bit counter and a debounced bit, both reset to 0.
  - If the synchronized value equals the debounced bit, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches `DEBOUNCE-1` while still differing, the debounced bit flips and the counter clears the same edge.
  - Signals below: `da`, `db` (requests); `dva`, `dvb` (data).
- **FSM states:** IDLE, GNT_A, GNT_B, TURN. Registers:
  - `last`: the last granted side; resets to B, so A wins the first tie.
  - `hold`: the grant-length counter.
- **Pick rule**, used in IDLE and TURN:
  - `da & db`: grant the side that is not `last`.
  - `da` only: GNT_A.
  - `db` only: GNT_B.
  - Neither: IDLE.
  - On every entry to GNT_x, set `last` to x and `hold` to 0.
- **GNT_A** (GNT_B is symmetric):
  - `hold` increments and saturates at `MAX_HOLD-1`.
  - If `!da`, go to TURN.
  - Else if `db` and `hold == MAX_HOLD-1`, go to TURN and pulse `starved`.
  - Else stay.
- **TURN** lasts exactly one cycle. Both enables are low. The next state comes from the pick rule, so a preempted side that is still requesting loses to the waiting side.
- **Outputs.**
  - `drive_a` = (state == GNT_A) and `drive_b` = (state == GNT_B), decoded from the state register. No combinational path exists from inputs to outputs.
  - `value_x` = `dvx` & `drive_x`.

## Timing
- **Reset.** On the edge where `reset` is sampled high, all flops clear and the state becomes IDLE. `reset` has priority over every other event. Outputs after reset:
  - `drive_a`, `drive_b`, `value_a`, `value_b` = 0.
  - `owner` = 00, `starved` = 0.
  - `last` = B.
- **Reset mid-grant.** `drive_x` drops the edge after `reset` is sampled. A raw request still held after reset re-qualifies only after the full sync plus debounce latency.
- **Input latency.**
  - A raw change held stable reaches `da`/`db`/`dva`/`dvb` after 2 + `DEBOUNCE` edges.
  - A glitch shorter than `DEBOUNCE` cycles after synchronization is rejected.
- **Request to enable.** `drive_x` rises 1 edge after `dx` rises while the FSM is in IDLE, so raw press to `drive` takes 3 + `DEBOUNCE` edges (6 at default).
- **Release.**
  - `drive_x` falls the edge after `dx` falls.
  - This is followed by one TURN cycle before any new grant.
- **Simultaneous release.** If the waiting side releases during TURN, the pick rule returns IDLE.
- **Hand-off.** At least one cycle elapses with both enables low between any A grant and any B grant.
- **Maximum grant with contention.** `drive_x` is high for `MAX_HOLD` cycles, then TURN. `starved` pulses the same edge TURN is entered.
- **No contention.** A grant is unbounded and `hold` stays saturated.

## Test plan
- **Reset.** Hold `reset` for 2 cycles with all inputs high, then release → all outputs 0 during reset. With `DEBOUNCE`=3, `drive_a`=1 and `owner`=01 appear 6 edges after reset release, because A wins the tie.
- **Glitch rejection.** Pulse raw `req_a` high for 2 cycles → `drive_a` stays 0. Hold it for 5 cycles → `drive_a` rises 6 edges after the press.
- **Data gating.** With A granted, toggle `val_a` (held ≥4 cycles) → `value_a` follows 5 edges later. `value_b` stays 0 while `val_b`=1 and B is not granted.
- **Hand-off.** A granted, B requesting, A released → sequence `owner` 01, 11, 10. `drive_a` and `drive_b` are never both 1 on any cycle.
- **Preemption.** `MAX_HOLD`=4, both held → `drive_a` high 4 cycles, TURN with `starved`=1, `drive_b` high 4 cycles, TURN, `drive_a` again. This alternates indefinitely.
- **Mid-grant reset.** Assert `reset` during GNT_B → next edge shows `drive_b`=0 and `owner`=00. Re-grant happens only after 5 + 1 edges.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request, data and grant signals between the button front end and bus_arbiter
interface bus_arbiter_if;
  logic       req_a;
  logic       req_b;
  logic       val_a;
  logic       val_b;
  logic       drive_a;
  logic       drive_b;
  logic       value_a;
  logic       value_b;
  logic [1:0] owner;
  logic       starved;

  modport master (
    output req_a, req_b, val_a, val_b,
    input  drive_a, drive_b, value_a, value_b, owner, starved
  );

  modport slave (
    input  req_a, req_b, val_a, val_b,
    output drive_a, drive_b, value_a, value_b, owner, starved
  );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - synchronize, debounce and round-robin arbitrate two bus drivers
module bus_arbiter #(
  parameter int DEBOUNCE = 3,
  parameter int MAX_HOLD = 200
) (
  input  logic          hz100,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  localparam logic [3:0] DB_LAST   = 4'(DEBOUNCE - 1);
  localparam logic [9:0] HOLD_LAST = 10'(MAX_HOLD - 1);

  // Encoding doubles as the owner code seen by the outside world.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10,
    TURN  = 2'b11
  } state_t;

  // Bit order: 0 req_a, 1 req_b, 2 val_a, 3 val_b.
  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] deb;
  logic [3:0] cnt [4];

  logic da, db, dva, dvb;

  state_t     state, state_n, pick;
  logic       last_b, last_b_n;    // 1 when B was granted last
  logic [9:0] hold, hold_n;
  logic       starved_q, starved_n;

  assign raw = {bus.val_b, bus.val_a, bus.req_b, bus.req_a};

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge hz100) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debouncer: flip only after DEBOUNCE consecutive differing samples.
  always_ff @(posedge hz100) begin
    if (reset) begin
      deb <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  assign da  = deb[0];
  assign db  = deb[1];
  assign dva = deb[2];
  assign dvb = deb[3];

  // Round-robin pick: on a tie the side not served last wins.
  always_comb begin
    pick = IDLE;
    if (da && db)  pick = last_b ? GNT_A : GNT_B;
    else if (da)   pick = GNT_A;
    else if (db)   pick = GNT_B;
  end

  // Arbiter state register.
  always_ff @(posedge hz100) begin
    if (reset) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      hold      <= '0;
      starved_q <= 1'b0;
    end else begin
      state     <= state_n;
      last_b    <= last_b_n;
      hold      <= hold_n;
      starved_q <= starved_n;
    end
  end

  // Next-state logic: grants end on release or on hold expiry under contention.
  always_comb begin
    state_n   = state;
    last_b_n  = last_b;
    hold_n    = hold;
    starved_n = 1'b0;
    case (state)
      IDLE, TURN: begin
        state_n = pick;
        if (pick == GNT_A) begin
          last_b_n = 1'b0;
          hold_n   = '0;
        end else if (pick == GNT_B) begin
          last_b_n = 1'b1;
          hold_n   = '0;
        end
      end
      GNT_A: begin
        if (hold != HOLD_LAST) hold_n = hold + 10'd1;
        if (!da) begin
          state_n = TURN;
        end else if (db && hold == HOLD_LAST) begin
          state_n   = TURN;
          starved_n = 1'b1;
        end
      end
      GNT_B: begin
        if (hold != HOLD_LAST) hold_n = hold + 10'd1;
        if (!db) begin
          state_n = TURN;
        end else if (da && hold == HOLD_LAST) begin
          state_n   = TURN;
          starved_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.drive_a = (state == GNT_A);
  assign bus.drive_b = (state == GNT_B);
  assign bus.value_a = dva & (state == GNT_A);
  assign bus.value_b = dvb & (state == GNT_B);
  assign bus.owner   = state;
  assign bus.starved = starved_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter against a behavioural model
module tb_bus_arbiter;
  localparam int DEBOUNCE = 3;
  localparam int MAX_HOLD = 4;

  logic hz100 = 1'b0;
  logic reset = 1'b1;

  bus_arbiter_if bus ();

  bus_arbiter #(.DEBOUNCE(DEBOUNCE), .MAX_HOLD(MAX_HOLD)) dut (
    .hz100 (hz100),
    .reset (reset),
    .bus   (bus)
  );

  always #5 hz100 = ~hz100;

  typedef struct packed {
    logic       drive_a;
    logic       drive_b;
    logic       value_a;
    logic       value_b;
    logic [1:0] owner;
    logic       starved;
  } obs_t;

  obs_t expq[$];
  int checks   = 0;
  int failures = 0;

  // Model state: raw-sample delay line, sample windows, clean levels, grant bookkeeping.
  bit dl1 [4];
  bit dl2 [4];
  bit win [4][DEBOUNCE];
  bit mdeb [4];
  int m_grant;   // 0 none, 1 A, 2 B
  int m_last;    // 1 A, 2 B
  int m_gcnt;    // cycles spent in the current grant
  bit m_turn;
  bit m_starved;

  always @(posedge hz100) begin : model
    bit   raw [4];
    bit   da, db, mine, other, all_diff;
    int   pk;
    obs_t e;
    raw[0] = bus.req_a; raw[1] = bus.req_b; raw[2] = bus.val_a; raw[3] = bus.val_b;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        dl1[i] = 0; dl2[i] = 0; mdeb[i] = 0;
        for (int j = 0; j < DEBOUNCE; j++) win[i][j] = 0;
      end
      m_grant = 0; m_last = 2; m_gcnt = 0; m_turn = 0; m_starved = 0;
    end else begin
      da = mdeb[0];
      db = mdeb[1];
      m_starved = 0;
      if (m_grant == 0) begin
        pk = 0;
        if (da && db)  pk = (m_last == 1) ? 2 : 1;
        else if (da)   pk = 1;
        else if (db)   pk = 2;
        m_turn  = 0;
        m_grant = pk;
        if (pk != 0) begin
          m_last = pk;
          m_gcnt = 1;
        end
      end else begin
        mine  = (m_grant == 1) ? da : db;
        other = (m_grant == 1) ? db : da;
        if (!mine) begin
          m_grant = 0; m_turn = 1;
        end else if (other && m_gcnt >= MAX_HOLD) begin
          m_grant = 0; m_turn = 1; m_starved = 1;
        end else begin
          m_gcnt++;
        end
      end
      // A clean level changes once the last DEBOUNCE synchronized samples all disagree with it.
      for (int i = 0; i < 4; i++) begin
        for (int j = DEBOUNCE - 1; j > 0; j--) win[i][j] = win[i][j-1];
        win[i][0] = dl2[i];
        all_diff = 1;
        for (int j = 0; j < DEBOUNCE; j++) if (win[i][j] == mdeb[i]) all_diff = 0;
        if (all_diff) mdeb[i] = !mdeb[i];
      end
      for (int i = 0; i < 4; i++) begin
        dl2[i] = dl1[i];
        dl1[i] = raw[i];
      end
    end
    e.drive_a = (m_grant == 1);
    e.drive_b = (m_grant == 2);
    e.value_a = mdeb[2] && (m_grant == 1);
    e.value_b = mdeb[3] && (m_grant == 2);
    e.owner   = m_turn ? 2'b11 : 2'(m_grant);
    e.starved = m_starved;
    expq.push_back(e);
  end

  always @(negedge hz100) begin : monitor
    obs_t e, act;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      act = {bus.drive_a, bus.drive_b, bus.value_a, bus.value_b, bus.owner, bus.starved};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL outputs t=%0t actual da/db/va/vb/own/stv=%b required=%b", $time, act, e);
      end
      checks++;
      if (bus.drive_a && bus.drive_b) begin
        failures++;
        $display("FAIL exclusive t=%0t actual drive_a=%b drive_b=%b required not both 1",
                 $time, bus.drive_a, bus.drive_b);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge hz100);
    #1;
  endtask

  task automatic grant_latency(input string name, input bit side_b, input int want);
    int  n;
    bit  seen;
    n = -1;
    seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge hz100);
      #1;
      if (side_b ? bus.drive_b : bus.drive_a) begin
        seen = 1;
        n = i;
      end
    end
    checks++;
    if (n != want) begin
      failures++;
      $display("FAIL %s actual=%0d edges required=%0d edges", name, n, want);
    end
  endtask

  initial begin : stimulus
    bit got;
    bus.req_a = 1; bus.req_b = 1; bus.val_a = 1; bus.val_b = 1;
    reset = 1;
    cycles(2);
    reset = 0;
    grant_latency("reset_tie_latency", 1'b0, 6);

    // Glitch rejection, then a qualifying press.
    bus.req_a = 0; bus.req_b = 0; bus.val_a = 0; bus.val_b = 0;
    cycles(12);
    bus.req_a = 1;
    cycles(2);
    bus.req_a = 0;
    cycles(12);
    bus.req_a = 1;
    grant_latency("press_latency", 1'b0, 6);

    // Data gating while A owns the bus and B's data is high.
    bus.val_b = 1;
    for (int k = 0; k < 6; k++) begin
      bus.val_a = ~bus.val_a;
      cycles(4 + (k % 3));
    end

    // Hand-off A -> B.
    bus.req_b = 1;
    cycles(2);
    bus.req_a = 0;
    cycles(14);

    // Preemption: both held, grants alternate every MAX_HOLD cycles.
    bus.req_a = 1;
    cycles(40);

    // Simultaneous release.
    bus.req_a = 0; bus.req_b = 0;
    cycles(12);

    // Mid-grant reset during GNT_B.
    bus.req_b = 1;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      cycles(1);
      if (bus.owner == 2'b10) got = 1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL gnt_b_wait actual owner=%b required=10 within 30 cycles", bus.owner);
    end
    reset = 1;
    cycles(1);
    checks++;
    if (bus.drive_b !== 1'b0 || bus.owner !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_grant actual drive_b=%b owner=%b required drive_b=0 owner=00",
               bus.drive_b, bus.owner);
    end
    reset = 0;
    grant_latency("regrant_latency", 1'b1, 6);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) bus.req_a = ~bus.req_a;
      if ($urandom_range(7) == 0) bus.req_b = ~bus.req_b;
      if ($urandom_range(5) == 0) bus.val_a = ~bus.val_a;
      if ($urandom_range(5) == 0) bus.val_b = ~bus.val_b;
      reset = ($urandom_range(399) == 0);
      cycles(1);
    end
    reset = 0;
    cycles(3);
    @(negedge hz100);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
